data_memory_bank: RTL and testbench
===================================

// Module: data_memory_bank
// PURPOSE
//  Parametrised word-addressed data memory for the datapath MEM stage, successor to the fixed 32x32 data memory.
//  Adds byte-lane write strobes, registered 1-cycle reads with a valid flag, address range/alignment checking,
//  and a self-initialising sequence after reset that preloads every word over DEPTH cycles.
//  Sits between the ALU address output and the write-back mux; the pipeline stalls while ready=0.
// PARAMETERS
//  DATA_W     32  data word width in bits; multiple of 8
//  DEPTH      64  number of words; power of two, >= 2
//  ADDR_W     32  byte-address width on the address port
//  INIT_MODE  0   preload pattern: 0 = word i holds i, 1 = all words zero
// PORTS
//  CLK        in   1         clock, all state on rising edge
//  RESET_N    in   1         synchronous reset, active low
//  address    in   ADDR_W    byte address; word index = address >> log2(DATA_W/8)
//  writeData  in   DATA_W    write data
//  byteEn     in   DATA_W/8  write strobe per byte lane; bit k enables writeData[8k+7:8k]
//  memRead    in   1         read request, sampled when ready=1
//  memWrite   in   1         write request, sampled when ready=1
//  ready      out  1         1 = requests accepted this cycle; 0 during preload
//  readData   out  DATA_W    registered read result
//  readValid  out  1         1-cycle pulse: readData holds result of a read accepted the previous cycle
//  error      out  1         1-cycle pulse: access accepted the previous cycle was rejected
// BEHAVIOUR
//  Reset: one clock and one reset; reset is synchronous and active-low (RESET_N sampled on rising CLK).
//   RESET_N=0 at an edge -> state INIT, init counter=0, ready=0, readData=0, readValid=0, error=0.
//   Applies mid-operation too: any in-flight read result is discarded, no pulse is produced.
//  FSM states: INIT, RUN.
//   INIT: each cycle writes word[cnt] = (INIT_MODE==0 ? cnt zero-extended to DATA_W : 0), then cnt++.
//         The cycle that writes word DEPTH-1 -> RUN. Preload takes exactly DEPTH cycles after reset release.
//         ready=0; memRead/memWrite are ignored, not queued.
//   RUN:  ready=1 every cycle; remains in RUN until reset.
//  Accepted access (RUN, memRead|memWrite): checks run in the same cycle.
//   misaligned = address low log2(DATA_W/8) bits != 0; range = word index >= DEPTH.
//   Either check fails -> no memory update; next cycle error=1. If memRead was also asserted,
//   readValid=1 and readData=0 in that same cycle.
//  Write: word[idx] updated at the accepting edge, only lanes with byteEn=1; byteEn=0 -> no change and no error.
//  Read: the accepting edge captures word[idx] into readData; readValid=1 for the next cycle only.
//   readData holds its value until the next completed read or reset.
//  Simultaneous read+write, same cycle, same address: write-first. readData = merged new word
//   (enabled lanes from writeData, the others from the old word).
//  Back-to-back reads: one per cycle, readValid held high continuously, no bubbles.
//  Index wrap: none; out-of-range is reported as an error and never aliased.
// STRUCTURE
//  Package mem_pkg: state enum {INIT, RUN}, INIT_MODE constants (INIT_INDEX=0, INIT_ZERO=1),
//   function lane_merge(old, new, byteEn).
//  Sub-module mem_init_seq: cnt register, done flag and preload address/data generation; instantiated once.
//  Storage is a flat reg array [0:DEPTH-1]; a single write port is muxed between mem_init_seq and the request path.
// TESTING
//  1 Reset release (DEPTH=64): ready=0 for exactly 64 cycles, then 1; reads of words 0..63 return 0..63.
//  2 Write addr=0x10, data=0xDEADBEEF, byteEn=4'b0101 over word 4 = 0x4 -> next read gives 0x00AD00EF.
//  3 Same-cycle read+write addr=0x8, data=0x12345678, byteEn=4'hF -> next cycle readValid=1, readData=0x12345678.
//  4 Read addr=0x6 (misaligned) or 0x100 (range) -> error=1, readValid=1, readData=0; memory contents unchanged.
//  5 RESET_N=0 the cycle after a read is accepted -> no readValid pulse; preload restarts and word 4 reads back as 4.
//  6 Requests during INIT (write addr=0x0, data=0xFF) are ignored -> after preload, word 0 reads back as 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types, preload-mode constants and byte-lane merge helper for the data memory bank.
package mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned INIT_INDEX = 0;
  localparam int unsigned INIT_ZERO  = 1;

  // Widest word the merge helper handles; callers cast in and out at their own width.
  localparam int unsigned MERGE_W     = 1024;
  localparam int unsigned MERGE_LANES = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] lane_merge(
    input logic [MERGE_W-1:0]     old_word,
    input logic [MERGE_W-1:0]     new_word,
    input logic [MERGE_LANES-1:0] byte_en
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int k = 0; k < int'(MERGE_LANES); k++) begin
      if (byte_en[k]) res[k*8 +: 8] = new_word[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Preload sequencer: walks word indices 0..DEPTH-1 once after reset and supplies the preload data.
module mem_init_seq
  import mem_pkg::*;
#(
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned DEPTH     = 64,
  parameter  int unsigned INIT_MODE = 0,
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              en,
  output logic [IDX_W-1:0]  init_addr_c,
  output logic [DATA_W-1:0] init_data_c,
  output logic              init_last_c,
  output logic              done
);

  logic [IDX_W-1:0] cnt;

  assign init_addr_c = cnt;
  assign init_last_c = (cnt == IDX_W'(DEPTH - 1));
  assign init_data_c = (INIT_MODE == INIT_INDEX) ? DATA_W'(cnt) : '0;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (en && !done) begin
      cnt <= cnt + IDX_W'(1);
      if (init_last_c) done <= 1'b1;
    end
  end

endmodule

// File: rtl/data_memory_bank.sv
// Word-addressed MEM-stage data memory: byte-lane writes, registered reads, access checks, self-preload.
module data_memory_bank
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned INIT_MODE = 0
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   writeData,
  input  logic [DATA_W/8-1:0] byteEn,
  input  logic                memRead,
  input  logic                memWrite,
  output logic                ready,
  output logic [DATA_W-1:0]   readData,
  output logic                readValid,
  output logic                error
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_e            state, state_d;
  logic              ready_d, read_valid_d, error_d;
  logic [DATA_W-1:0] read_data_d;

  logic [IDX_W-1:0]  init_addr_c;
  logic [DATA_W-1:0] init_data_c;
  logic              init_last_c, init_done;

  logic              mem_we_c;
  logic [IDX_W-1:0]  mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  logic [ADDR_W-1:0] word_addr_c;
  logic [IDX_W-1:0]  idx_c;
  logic              bad_c;
  logic [BYTES-1:0]  be_eff_c;
  logic [DATA_W-1:0] merged_c;

  mem_init_seq #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_MODE (INIT_MODE)
  ) u_init (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .en          (state == INIT),
    .init_addr_c (init_addr_c),
    .init_data_c (init_data_c),
    .init_last_c (init_last_c),
    .done        (init_done)
  );

  // Request decode; merged_c is the write-first view of the addressed word.
  assign word_addr_c = address >> OFF_W;
  assign idx_c       = word_addr_c[IDX_W-1:0];
  assign bad_c       = ((address & ADDR_W'(BYTES - 1)) != '0) ||
                       (word_addr_c >= ADDR_W'(DEPTH));
  assign be_eff_c    = memWrite ? byteEn : '0;
  assign merged_c    = DATA_W'(lane_merge(MERGE_W'(mem[idx_c]), MERGE_W'(writeData),
                                          MERGE_LANES'(be_eff_c)));

  always_comb begin
    state_d      = state;
    ready_d      = 1'b0;
    read_data_d  = readData;
    read_valid_d = 1'b0;
    error_d      = 1'b0;
    mem_we_c     = 1'b0;
    mem_waddr_c  = init_addr_c;
    mem_wdata_c  = init_data_c;
    unique case (state)
      INIT: begin
        mem_we_c = !init_done;
        if (init_last_c) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        ready_d = 1'b1;
        if (memRead || memWrite) begin
          if (bad_c) begin
            error_d = 1'b1;
            if (memRead) begin
              read_valid_d = 1'b1;
              read_data_d  = '0;
            end
          end else begin
            if (memWrite && (byteEn != '0)) begin
              mem_we_c    = 1'b1;
              mem_waddr_c = idx_c;
              mem_wdata_c = merged_c;
            end
            if (memRead) begin
              read_valid_d = 1'b1;
              read_data_d  = merged_c;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= INIT;
      ready     <= 1'b0;
      readData  <= '0;
      readValid <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      ready     <= ready_d;
      readData  <= read_data_d;
      readValid <= read_valid_d;
      error     <= error_d;
    end
  end

  // Single write port shared by the preload sequencer and the request path.
  always_ff @(posedge CLK) begin
    if (RESET_N && mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

endmodule

// File: tb/tb_data_memory_bank.sv
// Scoreboard bench for data_memory_bank: directed requests push expectations, a monitor checks responses.
module tb_data_memory_bank;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic [3:0]  byteEn = '0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic        ready;
  logic [31:0] readData;
  logic        readValid;
  logic        error;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  data_memory_bank #(
    .DATA_W(32), .DEPTH(64), .ADDR_W(32), .INIT_MODE(0)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .address   (address),
    .writeData (writeData),
    .byteEn    (byteEn),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .ready     (ready),
    .readData  (readData),
    .readValid (readValid),
    .error     (error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every readValid/error pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_response: no pulse seen, required one at cycle %0d (now %0d)", q[0].due, cyc);
      void'(q.pop_front());
    end
    if (readValid || error) begin
      checks++;
      if (q.size() == 0 || q[0].due != cyc) begin
        errors++;
        $display("FAIL unexpected_response: readValid=%0b error=%0b readData=%h at cycle %0d, required none",
                 readValid, error, readData, cyc);
      end else begin
        e = q.pop_front();
        if (readValid !== e.valid || error !== e.err || (e.valid && readData !== e.data)) begin
          errors++;
          $display("FAIL response: got valid=%0b err=%0b data=%h, required valid=%0b err=%0b data=%h",
                   readValid, error, readData, e.valid, e.err, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic rd, input logic wr, input logic [31:0] ed, input logic ee);
    exp_t e;
    @(negedge CLK);
    address   = a;
    writeData = wd;
    byteEn    = be;
    memRead   = rd;
    memWrite  = wr;
    if (rd || ee) begin
      e.valid = rd;
      e.data  = ed;
      e.err   = ee;
      e.due   = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      memRead  = 1'b0;
      memWrite = 1'b0;
    end
  endtask

  // Releases reset with whatever request is on the pins and counts cycles with ready low.
  task automatic release_and_count(input string name);
    int n;
    n = 0;
    RESET_N = 1'b1;
    while (!ready && n < 200) begin
      n++;
      @(negedge CLK);
    end
    memRead  = 1'b0;
    memWrite = 1'b0;
    chk(name, 32'(n), 32'd64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_readValid", 32'(readValid), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_readData", readData, 32'd0);

    // Preload length and contents, read back-to-back.
    release_and_count("preload_ready_low_cycles");
    for (int i = 0; i < 64; i++) issue(32'(i * 4), '0, 4'h0, 1'b1, 1'b0, 32'(i), 1'b0);
    idle(1);

    // Partial-lane write, then read.
    issue(32'h10, 32'hDEADBEEF, 4'b0101, 1'b0, 1'b1, '0, 1'b0);
    issue(32'h10, '0, 4'h0, 1'b1, 1'b0, 32'h00AD00EF, 1'b0);
    // Same-cycle read+write is write-first.
    issue(32'h08, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'h12345678, 1'b0);
    issue(32'h08, '0, 4'h0, 1'b1, 1'b0, 32'h12345678, 1'b0);
    // Zero strobe write leaves the word unchanged.
    issue(32'h0C, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, '0, 1'b0);
    issue(32'h0C, '0, 4'h0, 1'b1, 1'b0, 32'h3, 1'b0);
    // Misaligned and out-of-range accesses.
    issue(32'h06, '0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    issue(32'h100, '0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    issue(32'h12, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, '0, 1'b1);
    issue(32'h100, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, '0, 1'b1);
    issue(32'h10, '0, 4'h0, 1'b1, 1'b0, 32'h00AD00EF, 1'b0);
    issue(32'h04, '0, 4'h0, 1'b1, 1'b0, 32'h1, 1'b0);
    issue(32'h00, '0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1 & 1'b0);
    idle(2);
    chk("readData_held", readData, 32'h0);

    // Reset on the edge that would accept a read: no pulse, outputs cleared.
    issue(32'h08, '0, 4'h0, 1'b1, 1'b0, '0, 1'b0);
    void'(q.pop_back());
    RESET_N = 1'b0;
    @(negedge CLK);
    chk("midreset_readValid", 32'(readValid), 32'd0);
    chk("midreset_readData", readData, 32'd0);
    chk("midreset_ready", 32'(ready), 32'd0);
    idle(1);

    // Requests held during preload must be ignored.
    address   = 32'h0;
    writeData = 32'hFF;
    byteEn    = 4'hF;
    memRead   = 1'b1;
    memWrite  = 1'b1;
    release_and_count("repreload_ready_low_cycles");
    issue(32'h00, '0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h10, '0, 4'h0, 1'b1, 1'b0, 32'h4, 1'b0);
    issue(32'h08, '0, 4'h0, 1'b1, 1'b0, 32'h2, 1'b0);
    issue(32'hFC, '0, 4'h0, 1'b1, 1'b0, 32'd63, 1'b0);
    idle(3);

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
